// File: rtl/gf2_solution_streamer_if.sv
// rtl/gf2_solution_streamer_if.sv - stream bus carrying solution vectors out of the streamer
interface gf2_solution_streamer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/gf2_solution_streamer.sv
// rtl/gf2_solution_streamer.sv - enumerates every solution of an RREF GF(2) system as stream beats
module gf2_solution_streamer #(
  parameter int ROWS       = 4,
  parameter int COLS       = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [COLS-1:0]         RREF [ROWS],
  output logic                    busy,
  output logic                    done,
  output logic                    no_solution,
  gf2_solution_streamer_if.master solution_stream
);

  localparam int NV = COLS - 1;      // number of variables
  localparam int RW = $clog2(COLS);  // wide enough for a var index, a rank and the free count

  if (DATA_WIDTH < NV) begin : g_bad_width
    $error("gf2_solution_streamer: DATA_WIDTH must be >= COLS-1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ANALYSE, S_EMIT, S_FINISH} state_t;

  state_t                    r_state;
  logic [ROWS-1:0][COLS-1:0] r_mat;
  logic [ROWS-1:0][RW-1:0]   r_piv;
  logic [ROWS-1:0]           r_piv_ok;
  logic [NV-1:0]             r_free;
  logic [NV-1:0][RW-1:0]     r_rank;
  logic [COLS-1:0]           r_last_k;
  logic                      r_incons;
  logic [COLS-1:0]           r_k;
  logic                      r_tvalid;
  logic                      r_tlast;
  logic [DATA_WIDTH-1:0]     r_tdata;
  logic                      r_no_solution;
  logic                      r_busy;
  logic                      r_done;

  logic [ROWS-1:0][RW-1:0]   w_piv;
  logic [ROWS-1:0]           w_piv_ok;
  logic [NV-1:0]             w_free;
  logic [NV-1:0][RW-1:0]     w_rank;
  logic [RW-1:0]             w_nfree;
  logic [COLS-1:0]           w_last_k;
  logic                      w_incons;

  logic                      w_analyse;
  logic [ROWS-1:0][RW-1:0]   w_s_piv;
  logic [ROWS-1:0]           w_s_piv_ok;
  logic [NV-1:0]             w_s_free;
  logic [NV-1:0][RW-1:0]     w_s_rank;
  logic [COLS-1:0]           w_s_last_k;
  logic                      w_s_incons;
  logic [COLS-1:0]           w_k;
  logic [NV-1:0]             w_x;
  logic [DATA_WIDTH-1:0]     w_beat_data;
  logic                      w_beat_last;
  logic                      w_hs;

  assign solution_stream.tvalid = r_tvalid;
  assign solution_stream.tlast  = r_tlast;
  assign solution_stream.tdata  = r_tdata;
  assign no_solution            = r_no_solution;
  assign busy                   = r_busy;
  assign done                   = r_done;
  assign w_hs                   = r_tvalid & solution_stream.tready;

  // Structural analysis of the latched matrix: pivots, free vars, their ranks, consistency
  always_comb begin
    w_piv    = '0;
    w_piv_ok = '0;
    w_free   = '1;
    w_rank   = '0;
    w_nfree  = '0;
    w_incons = 1'b0;
    // Scan from the highest var down so the lowest set coefficient wins
    for (int r = 0; r < ROWS; r++) begin
      for (int v = NV - 1; v >= 0; v--) begin
        if (r_mat[r][COLS-1-v]) begin
          w_piv_ok[r] = 1'b1;
          w_piv[r]    = RW'(v);
        end
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      for (int v = 0; v < NV; v++) begin
        if (w_piv_ok[r] && (w_piv[r] == RW'(v))) w_free[v] = 1'b0;
      end
    end
    for (int v = 0; v < NV; v++) begin
      w_rank[v] = w_nfree;
      if (w_free[v]) w_nfree = w_nfree + 1'b1;
    end
    for (int r = 0; r < ROWS; r++) begin
      if (!w_piv_ok[r]) w_incons = w_incons | r_mat[r][0];
    end
    w_last_k = (COLS'(1) << w_nfree) - COLS'(1);
  end

  // First beat is built from the live analysis; later beats from the registered copy and k+1
  always_comb begin
    w_analyse  = (r_state == S_ANALYSE);
    w_s_piv    = w_analyse ? w_piv    : r_piv;
    w_s_piv_ok = w_analyse ? w_piv_ok : r_piv_ok;
    w_s_free   = w_analyse ? w_free   : r_free;
    w_s_rank   = w_analyse ? w_rank   : r_rank;
    w_s_last_k = w_analyse ? w_last_k : r_last_k;
    w_s_incons = w_analyse ? w_incons : r_incons;
    w_k        = w_analyse ? '0       : r_k + 1'b1;
  end

  // Solution vector for counter value w_k: free vars straight from k, pivots back-substituted
  always_comb begin
    logic acc;
    w_x = '0;
    acc = 1'b0;
    for (int v = 0; v < NV; v++) begin
      if (w_s_free[v]) w_x[v] = w_k[w_s_rank[v]];
    end
    for (int r = 0; r < ROWS; r++) begin
      if (w_s_piv_ok[r]) begin
        acc = r_mat[r][0];
        for (int v = 0; v < NV; v++) begin
          if (w_s_free[v] && r_mat[r][COLS-1-v]) acc = acc ^ w_x[v];
        end
        for (int v = 0; v < NV; v++) begin
          if (w_s_piv[r] == RW'(v)) w_x[v] = acc;
        end
      end
    end
    w_beat_data = w_s_incons ? '0 : DATA_WIDTH'(w_x);
    w_beat_last = w_s_incons | (w_k == w_s_last_k);
  end

  // Control FSM with registered stream outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_mat         <= '0;
      r_piv         <= '0;
      r_piv_ok      <= '0;
      r_free        <= '0;
      r_rank        <= '0;
      r_last_k      <= '0;
      r_incons      <= 1'b0;
      r_k           <= '0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_tdata       <= '0;
      r_no_solution <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            for (int r = 0; r < ROWS; r++) r_mat[r] <= RREF[r];
            r_busy  <= 1'b1;
            r_state <= S_ANALYSE;
          end
        end
        S_ANALYSE: begin
          r_piv         <= w_piv;
          r_piv_ok      <= w_piv_ok;
          r_free        <= w_free;
          r_rank        <= w_rank;
          r_last_k      <= w_last_k;
          r_incons      <= w_incons;
          r_k           <= '0;
          r_tvalid      <= 1'b1;
          r_tdata       <= w_beat_data;
          r_tlast       <= w_beat_last;
          r_no_solution <= w_incons;
          r_state       <= S_EMIT;
        end
        S_EMIT: begin
          if (w_hs) begin
            if (r_tlast) begin
              r_tvalid      <= 1'b0;
              r_tlast       <= 1'b0;
              r_tdata       <= '0;
              r_no_solution <= 1'b0;
              r_busy        <= 1'b0;
              r_done        <= 1'b1;
              r_state       <= S_FINISH;
            end else begin
              r_k     <= w_k;
              r_tdata <= w_beat_data;
              r_tlast <= w_beat_last;
            end
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
